// File: rtl/control_pkg.sv
// Shared constants and types for the MIPS main control unit.
// Optional feature macro: CONTROL_ILLEGAL_OP_EN (adds the illegal_op flag).
package control_pkg;

  // Primary opcode encodings (instruction bits 31:26)
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation classes handed to the ALU control stage
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // All datapath steering bits produced for one instruction
  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic       memtoReg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       jump;
    logic [1:0] aluOp;
`ifdef CONTROL_ILLEGAL_OP_EN
    logic       illegalOp;
`endif
  } ctrl_t;

endpackage

// File: rtl/mips_main_control_if.sv
// Opcode-in / control-out bundle between decode stage and datapath muxes.
// Optional feature macro: CONTROL_ILLEGAL_OP_EN (adds illegal_op).
interface mips_main_control_if;

  logic [5:0] c;
  logic       RegDst;
  logic       Branch;
  logic       MemRead;
  logic       MemtoReg;
  logic [1:0] Alu_op;
  logic       MemWrite;
  logic       AluSrc;
  logic       RegWrite;
  logic       J;
`ifdef CONTROL_ILLEGAL_OP_EN
  logic       illegal_op;
`endif

  // Instruction side: supplies the opcode, observes the control word
  modport master (
    output c,
    input  RegDst, Branch, MemRead, MemtoReg, Alu_op,
    input  MemWrite, AluSrc, RegWrite, J
`ifdef CONTROL_ILLEGAL_OP_EN
    , input illegal_op
`endif
  );

  // Control unit side: consumes the opcode, drives the control word
  modport slave (
    input  c,
    output RegDst, Branch, MemRead, MemtoReg, Alu_op,
    output MemWrite, AluSrc, RegWrite, J
`ifdef CONTROL_ILLEGAL_OP_EN
    , output illegal_op
`endif
  );

endinterface

// File: rtl/control_decode.sv
// Purely combinational opcode -> control word decoder.
// Optional feature macro: CONTROL_ILLEGAL_OP_EN (flags undecoded opcodes).
module control_decode
  import control_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  // Start from an all-zero (NOP) word so undecoded or unknown opcodes never write
  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.regDst   = 1'b1;
        ctrl_o.regWrite = 1'b1;
        ctrl_o.aluOp    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.memtoReg = 1'b1;
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memRead  = 1'b1;
        ctrl_o.aluOp    = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.memWrite = 1'b1;
        ctrl_o.aluOp    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch   = 1'b1;
        ctrl_o.aluOp    = ALUOP_SUB;
      end
      OP_ADDIU: begin
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.regWrite = 1'b1;
        ctrl_o.aluOp    = ALUOP_ADD;
      end
      OP_J: begin
        ctrl_o.jump     = 1'b1;
      end
      default: begin
`ifdef CONTROL_ILLEGAL_OP_EN
        ctrl_o.illegalOp = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/mips_main_control.sv
// MIPS main control unit: decodes the opcode and registers the control word.
// Optional feature macro: CONTROL_ILLEGAL_OP_EN (adds registered illegal_op).
module mips_main_control
  import control_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  mips_main_control_if.slave  bus
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  control_decode u_decode (
    .opcode_i (bus.c),
    .ctrl_o   (ctrl_d)
  );

  // Capture the decoded word each edge; reset clears it to the NOP pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.RegDst   = ctrl_q.regDst;
  assign bus.AluSrc   = ctrl_q.aluSrc;
  assign bus.MemtoReg = ctrl_q.memtoReg;
  assign bus.RegWrite = ctrl_q.regWrite;
  assign bus.MemRead  = ctrl_q.memRead;
  assign bus.MemWrite = ctrl_q.memWrite;
  assign bus.Branch   = ctrl_q.branch;
  assign bus.J        = ctrl_q.jump;
  assign bus.Alu_op   = ctrl_q.aluOp;
`ifdef CONTROL_ILLEGAL_OP_EN
  assign bus.illegal_op = ctrl_q.illegalOp;
`endif

endmodule

// File: tb/tb_mips_main_control.sv
// Directed bench for mips_main_control.
// Optional feature macro: CONTROL_ILLEGAL_OP_EN (also checks illegal_op).
module tb_mips_main_control;

  logic clk;
  logic rst;
  int   vecCount;
  int   missCount;

  mips_main_control_if bus ();

  mips_main_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected words: {RegDst,AluSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,J,Alu_op}
  localparam logic [9:0] EXP_NOP   = 10'b0000000000;
  localparam logic [9:0] EXP_RTYPE = 10'b1001000010;
  localparam logic [9:0] EXP_LW    = 10'b0111100000;
  localparam logic [9:0] EXP_SW    = 10'b0100010000;
  localparam logic [9:0] EXP_BEQ   = 10'b0000001001;
  localparam logic [9:0] EXP_ADDIU = 10'b0101000000;
  localparam logic [9:0] EXP_J     = 10'b0000000100;

  logic [5:0] opTable  [6];
  logic [9:0] expTable [6];

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Collect the DUT outputs in expected-word order
  function automatic logic [9:0] observed();
    return {bus.RegDst, bus.AluSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
            bus.MemWrite, bus.Branch, bus.J, bus.Alu_op};
  endfunction

  // Drive an opcode at the falling edge, then sample just after the next rising edge
  task automatic applyStimulus(input logic [5:0] op);
    @(negedge clk);
    bus.c = op;
    @(posedge clk);
    #1;
  endtask

  // Compare the control word against a hand-computed value
  task automatic checkOutput(input string tag, input logic [9:0] expected);
    logic [9:0] obs;
    obs = observed();
    vecCount++;
    assert (obs === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expected);
    end
    assert (!(obs[5] && obs[4]) && !(obs[3] && obs[2])) else begin
      missCount++;
      $error("[TB] FAIL %s_exclusive observed=%b expected=no overlap", tag, obs);
    end
  endtask

`ifdef CONTROL_ILLEGAL_OP_EN
  // Compare the illegal opcode flag
  task automatic checkIllegal(input string tag, input logic expected);
    vecCount++;
    assert (bus.illegal_op === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, bus.illegal_op, expected);
    end
  endtask
`endif

  initial begin
    vecCount  = 0;
    missCount = 0;
    opTable  = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001001, 6'b000010};
    expTable = '{EXP_RTYPE, EXP_LW, EXP_SW, EXP_BEQ, EXP_ADDIU, EXP_J};

    // Reset state with lw on the opcode bus
    rst   = 1'b1;
    bus.c = 6'b100011;
    #12;
    checkOutput("reset_initial", EXP_NOP);
`ifdef CONTROL_ILLEGAL_OP_EN
    checkIllegal("reset_illegal", 1'b0);
`endif

    // First rising edge after release decodes lw
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("lw_after_reset", EXP_LW);

    // Mid-cycle reset clears outputs without a clock edge
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", EXP_NOP);
    @(posedge clk);
    #1;
    checkOutput("reset_held", EXP_NOP);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("lw_release", EXP_LW);

    // Individual opcodes
    applyStimulus(6'b101011);
    checkOutput("sw", EXP_SW);
    applyStimulus(6'b000100);
    checkOutput("beq", EXP_BEQ);
    applyStimulus(6'b000000);
    checkOutput("rtype", EXP_RTYPE);
    applyStimulus(6'b001001);
    checkOutput("addiu", EXP_ADDIU);
    applyStimulus(6'b000010);
    checkOutput("j", EXP_J);

    // Unknown opcodes decode as NOP
    applyStimulus(6'b111111);
    checkOutput("unknown_3f", EXP_NOP);
`ifdef CONTROL_ILLEGAL_OP_EN
    checkIllegal("illegal_3f", 1'b1);
`endif
    applyStimulus(6'b001000);
    checkOutput("unknown_08", EXP_NOP);
`ifdef CONTROL_ILLEGAL_OP_EN
    checkIllegal("illegal_08", 1'b1);
`endif
    applyStimulus(6'b100011);
    checkOutput("lw_after_unknown", EXP_LW);
`ifdef CONTROL_ILLEGAL_OP_EN
    checkIllegal("illegal_clear", 1'b0);
`endif

    // Latency: before each edge the old pattern holds, after it the new one appears
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.c = opTable[i];
      #1;
      checkOutput($sformatf("hold_%0d", i), (i == 0) ? EXP_LW : expTable[i-1]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("lag_%0d", i), expTable[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
